// File: rtl/otter_prog_loader.sv
// rtl/otter_prog_loader.sv - UART-fed instruction memory loader for the programmable OTTER
module otter_prog_loader #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              mem_ready,
    input  logic              tx_ready,
    output logic              mcu_rst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]   T_ONE     = 1;
    localparam logic [ADDR_W:0] WI_ONE    = 1;
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [7:0]      START     = 8'h5A;
    localparam logic [7:0]      ACK       = 8'hA5;
    localparam logic [7:0]      NAK       = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_RESP
    } state_t;

    state_t            state;
    logic [16:0]       len;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [7:0]        chk;
    logic [31:0]       wbuf;
    logic [TW-1:0]     tcnt;
    logic              overrun;

    logic [16:0]       len_rx;
    logic [16:0]       next_words;
    logic              timed_out;

    assign len_rx     = {1'b0, len[15:8], rx_data};
    assign next_words = 17'(word_idx) + 17'd1;
    assign timed_out  = (tcnt == T_LAST);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mcu_rst   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            err       <= 1'b0;
            len       <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            chk       <= '0;
            wbuf      <= '0;
            tcnt      <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == START) begin
                        state    <= S_LEN_HI;
                        mcu_rst  <= 1'b1;
                        err      <= 1'b0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        chk      <= '0;
                        tcnt     <= '0;
                        overrun  <= 1'b0;
                    end
                end

                S_LEN_HI: begin
                    if (rx_valid) begin
                        len   <= {1'b0, rx_data, 8'h00};
                        tcnt  <= '0;
                        state <= S_LEN_LO;
                    end else if (timed_out) begin
                        state    <= S_RESP;
                        tx_valid <= 1'b1;
                        tx_data  <= NAK;
                        err      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + T_ONE;
                    end
                end

                S_LEN_LO: begin
                    if (rx_valid) begin
                        len  <= len_rx;
                        tcnt <= '0;
                        // Oversized loads are refused before any memory is touched.
                        if (len_rx > MAX_WORDS) begin
                            state    <= S_RESP;
                            tx_valid <= 1'b1;
                            tx_data  <= NAK;
                            err      <= 1'b1;
                        end else if (len_rx == 17'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (timed_out) begin
                        state    <= S_RESP;
                        tx_valid <= 1'b1;
                        tx_data  <= NAK;
                        err      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + T_ONE;
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        wbuf[{byte_idx, 3'b000} +: 8] <= rx_data;
                        chk      <= chk ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        tcnt     <= '0;
                        // Fourth byte goes straight onto the write port without waiting on wbuf.
                        if (byte_idx == 2'd3) begin
                            state     <= S_WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            mem_wdata <= {rx_data, wbuf[23:0]};
                        end
                    end else if (timed_out) begin
                        state    <= S_RESP;
                        tx_valid <= 1'b1;
                        tx_data  <= NAK;
                        err      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + T_ONE;
                    end
                end

                S_WRITE: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        word_idx <= word_idx + WI_ONE;
                        tcnt     <= '0;
                        if (overrun || rx_valid) begin
                            state    <= S_RESP;
                            tx_valid <= 1'b1;
                            tx_data  <= NAK;
                            err      <= 1'b1;
                        end else if (next_words == len) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_CHK: begin
                    if (rx_valid) begin
                        state    <= S_RESP;
                        tx_valid <= 1'b1;
                        tx_data  <= (rx_data == chk) ? ACK : NAK;
                        err      <= (rx_data != chk);
                    end else if (timed_out) begin
                        state    <= S_RESP;
                        tx_valid <= 1'b1;
                        tx_data  <= NAK;
                        err      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + T_ONE;
                    end
                end

                S_RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        mcu_rst  <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_prog_loader.sv
// tb/tb_otter_prog_loader.sv - randomized frame bench for otter_prog_loader
module tb_otter_prog_loader;

    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 100;
    localparam int MAXW        = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              mem_ready;
    logic              tx_ready;
    logic              mcu_rst;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    int ready_delay = 0;
    int wait_cnt = 0;
    int unstable_cnt = 0;
    int we_cycles = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [7:0]        tx_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [7:0]        exp_resp;

    logic              prev_we_pend = 1'b0;
    logic              prev_tx_pend = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic [7:0]        prev_tx;

    otter_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_ready(mem_ready), .tx_ready(tx_ready), .mcu_rst(mcu_rst),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Memory responder: raises mem_ready ready_delay cycles after a request appears.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_we) begin
                wait_cnt  = 0;
                mem_ready = (ready_delay == 0);
            end else begin
                mem_ready = (wait_cnt >= ready_delay);
                wait_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_we) we_cycles++;
        if (mem_we && prev_we_pend && (mem_addr !== prev_addr || mem_wdata !== prev_data)) unstable_cnt++;
        prev_we_pend = mem_we && !mem_ready;
        prev_addr    = mem_addr;
        prev_data    = mem_wdata;
        if (mem_we && mem_ready) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (tx_valid && prev_tx_pend && tx_data !== prev_tx) unstable_cnt++;
        prev_tx_pend = tx_valid && !tx_ready;
        prev_tx      = tx_data;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_data_q.delete();
        tx_q.delete();
        unstable_cnt = 0;
        we_cycles    = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (mem_we && n < 1000) begin
            tick();
            n++;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic make_frame(input int len, input bit bad, output bq_t f);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] l16;
        l16 = 16'(len);
        f = {};
        f.push_back(8'h5A);
        f.push_back(l16[15:8]);
        f.push_back(l16[7:0]);
        if (len > MAXW) return;
        x = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x ^= b;
        end
        if (bad) x ^= 8'(1 << $urandom_range(0, 7));
        f.push_back(x);
    endtask

    // Reference: parse the frame as a whole and derive writes and response byte.
    task automatic build_expect(input bq_t f);
        int         len;
        logic [7:0] x;
        exp_addr_q.delete();
        exp_data_q.delete();
        len = {f[1], f[2]};
        if (len > MAXW) begin
            exp_resp = 8'hEE;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < len; w++) begin
            exp_addr_q.push_back(ADDR_W'(w));
            exp_data_q.push_back({f[3 + 4*w + 3], f[3 + 4*w + 2], f[3 + 4*w + 1], f[3 + 4*w]});
        end
        for (int i = 3; i < 3 + 4 * len; i++) x ^= f[i];
        exp_resp = (f[3 + 4 * len] == x) ? 8'hA5 : 8'hEE;
    endtask

    function automatic bit writes_match();
        if (wr_addr_q.size() != exp_addr_q.size()) return 1'b0;
        foreach (exp_addr_q[i])
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mcu_rst, mem_we, tx_valid, busy, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {mcu_rst, mem_we, tx_valid, busy, err});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_buses: got addr=%h wdata=%h tx=%h want 0", mem_addr, mem_wdata, tx_data);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || mcu_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b mcu_rst=%b want 0 0", busy, mcu_rst);
        end
    endtask

    task automatic test_single_word();
        bq_t f;
        f = {8'h5A, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        clear_obs();
        build_expect(f);
        send_byte(f[0]);
        checks++;
        if (mcu_rst !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got mcu_rst=%b busy=%b want 1 1", mcu_rst, busy);
        end
        for (int i = 1; i < 7; i++) send_byte(f[i]);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL write_latency: got we=%b addr=%h data=%h want 1 0 12345678", mem_we, mem_addr, mem_wdata);
        end
        send_byte(f[7]);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || mcu_rst !== 1'b1) begin
            errors++;
            $display("FAIL ack_resp: got valid=%b data=%h mcu_rst=%b want 1 a5 1", tx_valid, tx_data, mcu_rst);
        end
        tick();
        checks++;
        if (mcu_rst !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL release: got mcu_rst=%b valid=%b busy=%b err=%b want 0 0 0 0", mcu_rst, tx_valid, busy, err);
        end
        checks++;
        if (!writes_match() || tx_q.size() != 1 || tx_q[0] !== exp_resp) begin
            errors++;
            $display("FAIL single_word_model: got %0d writes tx=%0d want %0d writes tx=%h", wr_addr_q.size(), tx_q.size(), exp_addr_q.size(), exp_resp);
        end
    endtask

    task automatic test_mem_wait();
        bq_t f;
        ready_delay = 5;
        make_frame(3, 1'b0, f);
        clear_obs();
        build_expect(f);
        send_frame(f);
        wait_idle();
        checks++;
        if (!writes_match() || tx_q.size() != 1 || tx_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL mem_wait_model: got %0d writes %0d tx want %0d writes ack", wr_addr_q.size(), tx_q.size(), exp_addr_q.size());
        end
        checks++;
        if (unstable_cnt != 0 || we_cycles != 18) begin
            errors++;
            $display("FAIL mem_wait_hold: got unstable=%0d we_cycles=%0d want 0 18", unstable_cnt, we_cycles);
        end
        ready_delay = 0;
    endtask

    task automatic test_bad_chk();
        bq_t f;
        f = {8'h5A, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        clear_obs();
        build_expect(f);
        send_frame(f);
        wait_idle();
        checks++;
        if (!writes_match() || tx_q.size() != 1 || tx_q[0] !== 8'hEE || err !== 1'b1 || mcu_rst !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk: got %0d writes %0d tx err=%b mcu_rst=%b want 1 write nak err=1 mcu_rst=0", wr_addr_q.size(), tx_q.size(), err, mcu_rst);
        end
        f = {8'h5A, 8'h00, 8'h00, 8'h00};
        clear_obs();
        build_expect(f);
        send_byte(f[0]);
        checks++;
        if (err !== 1'b0 || mcu_rst !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err=%b mcu_rst=%b want 0 1", err, mcu_rst);
        end
        for (int i = 1; i < 4; i++) send_byte(f[i]);
        wait_idle();
        checks++;
        if (wr_addr_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== exp_resp || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: got %0d writes %0d tx err=%b want 0 writes ack err=0", wr_addr_q.size(), tx_q.size(), err);
        end
    endtask

    task automatic test_length_bounds();
        bq_t f;
        make_frame(MAXW + 1, 1'b0, f);
        clear_obs();
        build_expect(f);
        send_frame(f);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
            errors++;
            $display("FAIL too_long_resp: got valid=%b data=%h want 1 ee", tx_valid, tx_data);
        end
        wait_idle();
        checks++;
        if (wr_addr_q.size() != 0 || err !== 1'b1 || tx_q.size() != 1) begin
            errors++;
            $display("FAIL too_long_writes: got %0d writes err=%b tx=%0d want 0 1 1", wr_addr_q.size(), err, tx_q.size());
        end
        make_frame(MAXW, 1'b0, f);
        clear_obs();
        build_expect(f);
        send_frame(f);
        wait_idle();
        checks++;
        if (!writes_match() || tx_q.size() != 1 || tx_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL max_len: got %0d writes %0d tx want %0d writes ack", wr_addr_q.size(), tx_q.size(), MAXW);
        end
    endtask

    task automatic test_timeout();
        bq_t f;
        int  k = 0;
        make_frame(2, 1'b0, f);
        clear_obs();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(f[i]);
        while (!tx_valid && k < 300) begin
            tick();
            k++;
        end
        checks++;
        if (k != TIMEOUT_CYC || tx_data !== 8'hEE) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d cycles data=%h want %0d ee", k, tx_data, TIMEOUT_CYC);
        end
        repeat (10) tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEE || unstable_cnt != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL tx_hold: got valid=%b data=%h unstable=%0d sent=%0d want 1 ee 0 0", tx_valid, tx_data, unstable_cnt, tx_q.size());
        end
        tx_ready = 1'b1;
        wait_idle();
        checks++;
        if (wr_addr_q.size() != 1 || wr_data_q[0] !== {f[6], f[5], f[4], f[3]} || err !== 1'b1 || tx_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_end: got %0d writes err=%b tx=%0d want 1 1 1", wr_addr_q.size(), err, tx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bq_t f;
        make_frame(2, 1'b0, f);
        clear_obs();
        for (int i = 0; i < 5; i++) send_byte(f[i]);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mcu_rst, mem_we, tx_valid, busy, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== 32'h0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got flags=%b addr=%h wdata=%h tx=%h want all 0", {mcu_rst, mem_we, tx_valid, busy, err}, mem_addr, mem_wdata, tx_data);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (tx_q.size() != 0 || wr_addr_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_silent: got tx=%0d writes=%0d busy=%b want 0 0 0", tx_q.size(), wr_addr_q.size(), busy);
        end
        make_frame(3, 1'b0, f);
        clear_obs();
        build_expect(f);
        send_frame(f);
        wait_idle();
        checks++;
        if (!writes_match() || tx_q.size() != 1 || tx_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL post_reset_load: got %0d writes %0d tx want %0d writes ack", wr_addr_q.size(), tx_q.size(), exp_addr_q.size());
        end
    endtask

    task automatic test_random_frames();
        bq_t f;
        for (int it = 0; it < 8; it++) begin
            ready_delay = $urandom_range(0, 3);
            make_frame($urandom_range(1, MAXW), ($urandom_range(0, 2) == 0), f);
            clear_obs();
            build_expect(f);
            send_frame(f);
            wait_idle();
            checks++;
            if (!writes_match()) begin
                errors++;
                $display("FAIL rand_writes[%0d]: got %0d writes want %0d (or contents differ)", it, wr_addr_q.size(), exp_addr_q.size());
            end
            checks++;
            if (tx_q.size() != 1 || tx_q[0] !== exp_resp || err !== (exp_resp == 8'hEE)) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got %0d tx err=%b want %h err=%b", it, tx_q.size(), err, exp_resp, exp_resp == 8'hEE);
            end
        end
        ready_delay = 0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_mem_wait();
        test_bad_chk();
        test_length_bounds();
        test_timeout();
        test_reset_mid();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
